// File: rtl/cascade_counter.sv
// WIDTH-bit synchronous up/down counter with programmable terminal value and
// 74163-style CEP/CET/TC cascading; optional hold-at-terminal saturation.
module cascade_counter #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             CEP,
    input  logic             CET,
    input  logic             _PE,
    input  logic             UP,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] LIMIT,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP
);

    if (WIDTH < 4 || WIDTH > 32 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("cascade_counter: WIDTH must be 4..32 and a multiple of 4");
    end

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             at_terminal;

    // Terminal is LIMIT going up and zero going down; an out-of-range value
    // (above LIMIT) rolls over naturally without being treated as terminal.
    assign at_terminal = UP ? (q_q == LIMIT) : (q_q == '0);

    // NOTE: defaults first so every path assigns q_d/wrap_d and no latch is inferred.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (!_PE) begin
            q_d = D;
        end else if (CEP && CET) begin
            wrap_d = at_terminal;
            if (at_terminal) begin
                if (!SATURATE) begin
                    q_d = UP ? '0 : LIMIT;
                end
            end else begin
                q_d = UP ? (q_q + 1'b1) : (q_q - 1'b1);
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so all registers sample together.
    always_ff @(posedge CP) begin
        if (MR) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q    = q_q;
    assign WRAP = wrap_q;
    assign TC   = CET & at_terminal;

endmodule

// File: doc/cascade_counter.md
# cascade_counter

Parametrised synchronous binary counter that generalises the 4-bit hct74163 to WIDTH bits. It adds up/down counting, a programmable terminal value (modulo wrap) and an optional saturating mode. It keeps 74163-style CEP/CET/TC cascading, so instances chain into wider counters. It is used for program-counter, address-generator and timer duties.

## Interface
Parameters:
- WIDTH, 8, counter width in bits; legal range 4..32, multiple of 4.
- SATURATE, 0, 0 = wrap at terminal, 1 = hold at terminal.

Ports:
- CP  in  1  clock; all state changes on the rising edge.
- MR  in  1  reset, synchronous and active-high.
- CEP  in  1  count enable, parallel.
- CET  in  1  count enable, trickle; also gates TC.
- _PE  in  1  parallel load, active-low.
- UP  in  1  direction: 1 = count up, 0 = count down.
- D  in  WIDTH  parallel load value.
- LIMIT  in  WIDTH  terminal value; sampled every cycle, not latched.
- Q  out  WIDTH  counter value, registered.
- TC  out  1  terminal count, combinational.
- WRAP  out  1  registered one-cycle pulse marking a terminal event.

## Operation
- Action priority at each CP rising edge:
  - MR=1: Q←0, WRAP←0.
  - else _PE=0: Q←D. CEP and CET are ignored, as on the 74163. WRAP←0.
  - else CEP=1 and CET=1: count step, described below.
  - else hold: Q unchanged, WRAP←0.
- Terminal condition:
  - AT = (UP ? Q==LIMIT : Q==0).
  - TC = CET & AT, combinational from Q, UP, LIMIT and CET.
- Count step, UP=1:
  - AT: Q←0, or Q unchanged when SATURATE=1.
  - otherwise Q←Q+1 modulo 2^WIDTH.
- Count step, UP=0:
  - AT: Q←LIMIT, or Q unchanged when SATURATE=1.
  - otherwise Q←Q−1.
- WRAP after a count step: WRAP←AT (wrap or saturate hold), otherwise 0.
- Out-of-range value (Q>LIMIT, e.g. after a load):
  - up-count continues to all-ones, then rolls to 0, then counts normally to LIMIT.
  - this natural rollover does not assert WRAP or TC, because AT is false.
- LIMIT=0:
  - up: AT is permanently true in the wrap cycle; Q stays 0 and WRAP pulses on every count step.
  - down: same behaviour.
- LIMIT may change at any time; the new value takes effect in the same cycle.
- Cascading:
  - low TC → high CET; shared CEP, _PE, MR, UP and CP.
  - the high stage steps only in the cycle the low stage is at terminal.
  - for a binary cascade, LIMIT of every stage is all-ones.
- No X propagation: all registers are defined after the first MR cycle.

## Timing
- Reset values after an MR edge: Q=0, WRAP=0. TC = CET & (UP ? LIMIT==0 : 1).
- Load latency is one edge: Q=D after the edge on which _PE=0 was sampled.
- Count latency is one edge per step; there is no pipelining.
- TC is valid in the same cycle Q, UP, LIMIT and CET settle. The chain depth N adds N TC→CET combinational hops; the design targets at least 4 stages at the system clock.
- WRAP is high for exactly the cycle following the terminal step. Consecutive terminal steps (LIMIT=0, or SATURATE=1 held at terminal) give WRAP high continuously.
- MR mid-count overrides a simultaneous load or count. WRAP clears on the same edge.
- Simultaneous _PE=0 with CEP=CET=1: the load wins and no step occurs.
- Direction change takes effect on the next edge with no dead cycle. TC reflects the new direction immediately.

## Test plan
- Reset/load, WIDTH=8, LIMIT=FF:
  - MR=1 for 1 edge → Q=00, WRAP=0.
  - _PE=0 with D=FE → Q=FE.
  - count 2 edges → Q=FF with TC=1, then Q=00 with WRAP=1 for one cycle.
- Modulo up, LIMIT=09, start Q=00, UP=1, 12 steps:
  - sequence 1..9,0,1,2.
  - WRAP high only after the 9→0 step; TC high only while Q=09.
- Down and saturate:
  - SATURATE=0, LIMIT=05, Q=01, UP=0, 3 steps → 00, 05, 04; WRAP after the 00→05 step.
  - SATURATE=1 instance, Q=01, UP=0, 3 steps → 00, 00, 00; WRAP high for 2 cycles.
- Enables and priority:
  - CET=0 → Q holds and TC=0.
  - CEP=0 → Q holds and TC still follows AT.
  - _PE=0 with CEP=CET=1 → Q=D.
  - MR=1 with _PE=0 → Q=00.
- Out of range: LIMIT=09, load D=FD, UP=1, 4 steps → FE, FF, 00, 01 with WRAP never asserted.
- Cascade, two WIDTH=4 instances, LIMIT=F, low TC→high CET:
  - load low=E, high=0; 2 steps → low=0, high=1.
  - free-run 256 steps from 00 → returns to 00; high TC asserts only at FF.
